// File: rtl/sha256_digest_finalize.sv
// -----------------------------------------------------------------------------
// sha256_digest_finalize
//
// Back end of the 64-stage unrolled SHA-256 chunk pipeline. A {valid,tag}
// delay line runs alongside the compression pipeline so that every chunk's
// valid bit and user tag reach the output at the same time as its final
// working variables. Stage S1 registers H' = ori + final, one 32-bit word at a
// time, with the carries discarded. Stage S2 pushes the digest into a
// show-ahead FIFO that drains through a valid/ready handshake. The in_ready
// output limits issue so that the chunks in flight plus the chunks buffered
// never exceed the FIFO depth.
//
// Optional feature macro: TARGET_CMP_EN
//   When defined, S1 also registers (digest <= target). The FIFO stores this as
//   one extra bit per entry and presents it on out_hit.
//   When undefined, there is no comparator. out_hit is tied to 0 and target is
//   ignored.
//
// Parameters
//   PIPE_LAT    cycles from chunk issue to final_*/ori_* valid
//   FIFO_DEPTH  digest FIFO entries (power of 2, >= 2)
//   TAG_W       width of the user tag carried with each chunk
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset (shared with the pipeline)
//   in_valid     chunk issued into the compression pipeline this cycle
//   in_tag       tag of the issued chunk
//   in_ready     issue permitted: inflight + fifo occupancy < FIFO_DEPTH
//   final_a..h   final working variables from the compression pipeline
//   ori_a..h     initial hash carried through the compression pipeline
//   target       difficulty target (used only with TARGET_CMP_EN)
//   out_valid    a digest is available at the FIFO head
//   out_ready    consumer accepts the head digest
//   out_digest   {H0',...,H7'}; H0' = ori_a + final_a occupies [255:224]
//   out_tag      tag of out_digest
//   out_hit      digest <= target (unsigned 256-bit)
//   drop_count   saturating count of digests lost because the FIFO was full
// -----------------------------------------------------------------------------
module sha256_digest_finalize #(
  parameter int PIPE_LAT   = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  input  logic [31:0]      final_a,
  input  logic [31:0]      final_b,
  input  logic [31:0]      final_c,
  input  logic [31:0]      final_d,
  input  logic [31:0]      final_e,
  input  logic [31:0]      final_f,
  input  logic [31:0]      final_g,
  input  logic [31:0]      final_h,
  input  logic [31:0]      ori_a,
  input  logic [31:0]      ori_b,
  input  logic [31:0]      ori_c,
  input  logic [31:0]      ori_d,
  input  logic [31:0]      ori_e,
  input  logic [31:0]      ori_f,
  input  logic [31:0]      ori_g,
  input  logic [31:0]      ori_h,
  input  logic [255:0]     target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_digest,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_hit,
  output logic [15:0]      drop_count
);

  localparam int IW = $clog2(PIPE_LAT + 3);    // inflight counter width
  localparam int PW = $clog2(FIFO_DEPTH);      // FIFO pointer width
  localparam int CW = $clog2(FIFO_DEPTH + 1);  // occupancy counter width
  localparam int OW = ((IW > CW) ? IW : CW) + 1;
`ifdef TARGET_CMP_EN
  localparam int EW = 256 + TAG_W + 1;         // {hit, tag, digest}
`else
  localparam int EW = 256 + TAG_W;             // {tag, digest}
`endif

  // ---------------------------------------------------------------------------
  // {valid, tag} delay line. Tap PIPE_LAT-1 lines up with final_*/ori_*.
  // ---------------------------------------------------------------------------
  logic [TAG_W:0] r_dl [PIPE_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) r_dl[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so that every
      // stage samples the value its neighbour held before this edge. A
      // blocking chain would collapse the whole shift register into one stage.
      r_dl[0] <= {in_valid, in_tag};
      for (int i = 1; i < PIPE_LAT; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  logic             w_tap_valid;
  logic [TAG_W-1:0] w_tap_tag;
  assign w_tap_valid = r_dl[PIPE_LAT-1][TAG_W];
  assign w_tap_tag   = r_dl[PIPE_LAT-1][TAG_W-1:0];

  // Each 32-bit sum is self-determined, so the carry out of every word is lost.
  logic [255:0] w_sum;
  assign w_sum = {ori_a + final_a, ori_b + final_b, ori_c + final_c, ori_d + final_d,
                  ori_e + final_e, ori_f + final_f, ori_g + final_g, ori_h + final_h};

  // ---------------------------------------------------------------------------
  // Stage S1: registered sums, tag, valid (and comparison result)
  // ---------------------------------------------------------------------------
  logic             r_s1_valid;
  logic [TAG_W-1:0] r_s1_tag;
  logic [255:0]     r_s1_digest;
  logic [EW-1:0]    w_s1_entry;

`ifdef TARGET_CMP_EN
  logic r_s1_hit;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_s1_hit <= 1'b0;
    else       r_s1_hit <= (w_sum <= target);
  end
  assign w_s1_entry = {r_s1_hit, r_s1_tag, r_s1_digest};
`else
  logic w_unused_target;
  assign w_unused_target = ^target;
  assign w_s1_entry      = {r_s1_tag, r_s1_digest};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_tag    <= '0;
      r_s1_digest <= '0;
    end else begin
      r_s1_valid  <= w_tap_valid;
      r_s1_tag    <= w_tap_tag;
      r_s1_digest <= w_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage S2: digest FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_drop;
  logic [IW-1:0] r_inflight;

  logic w_full, w_pop, w_write;
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = out_valid && out_ready;
  // When the FIFO is full, a push that coincides with a pop still lands. The
  // write slot equals the head being read out, and that slot becomes the tail.
  assign w_write = r_s1_valid && (!w_full || w_pop);

  // NOTE: the storage array has no reset. Reset only clears the pointers and
  // the occupancy count. Stale entries are never visible because the outputs
  // are gated by out_valid.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= w_s1_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_s1_valid && w_full && !w_pop && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  // Inflight covers chunks in the delay line and in S1. It is released on the
  // same edge that the FIFO occupancy takes over, so the sum stays continuous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= '0;
    end else begin
      case ({in_valid, r_s1_valid})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  logic [OW-1:0] w_occ;
  assign w_occ    = OW'(r_inflight) + OW'(r_count);
  assign in_ready = (w_occ < OW'(FIFO_DEPTH));

  // ---------------------------------------------------------------------------
  // Outputs: the head entry, gated to zero while the FIFO is empty
  // ---------------------------------------------------------------------------
  logic [EW-1:0] w_head;
  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = (r_count != '0);
  assign out_digest = out_valid ? w_head[255:0] : '0;
  assign out_tag    = out_valid ? w_head[256 +: TAG_W] : '0;
  assign drop_count = r_drop;
`ifdef TARGET_CMP_EN
  assign out_hit    = out_valid & w_head[EW-1];
`else
  assign out_hit    = 1'b0;
`endif

endmodule
